// File: rtl/i2c_target.sv
// I2C target with a 16-byte register file: pointer-then-data writes, streaming reads.
// Optional `I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_target #(
  parameter logic [6:0] ADDR      = 7'h3C,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [3:0] wr_idx,
  output logic [7:0] wr_data,
  input  logic [3:0] host_idx,
  output logic [7:0] host_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  // Synchronizers reset high so an idle bus produces no spurious edges.
  logic [1:0] scl_sy, sda_sy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
    end

  logic scl_f, sda_f;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
    end else begin
      scl_h <= {scl_h[0], scl_sy[1]};
      sda_h <= {sda_h[0], sda_sy[1]};
    end
  assign scl_f = (scl_sy[1] & scl_h[0]) | (scl_sy[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
  assign sda_f = (sda_sy[1] & sda_h[0]) | (sda_sy[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
`else
  assign scl_f = scl_sy[1];
  assign sda_f = sda_sy[1];
`endif

  logic scl_d, sda_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  sh, sh_n;
  logic [3:0]  ptr, ptr_n, ptr_inc;
  logic        rnw, rnw_n, oe_n, busy_n, we;
  logic [7:0]  regs [16];
  logic [7:0]  byte_in, rd_byte, rd_next;

  assign byte_in = {sh[6:0], sda_f};
  assign ptr_inc = ptr + 4'd1;
  assign rd_byte = regs[ptr];
  assign rd_next = regs[ptr_inc];

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      ptr     <= '0;
      rnw     <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      ptr     <= ptr_n;
      rnw     <= rnw_n;
      sda_oe  <= oe_n;
      busy    <= busy_n;
    end

  // ACK states use sda_oe itself as the phase flag: first fall asserts, second releases.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    ptr_n     = ptr;
    rnw_n     = rnw;
    oe_n      = sda_oe;
    busy_n    = busy;
    we        = 1'b0;
    if (stop_c) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_c) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          sh_n      = byte_in;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_in[7:1] == ADDR) begin
              state_n = S_ADDR_ACK;
              rnw_n   = byte_in[0];
              busy_n  = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) oe_n = 1'b1;
          else if (rnw) begin
            oe_n    = ~rd_byte[7];
            sh_n    = {rd_byte[6:0], 1'b0};
            state_n = S_RDATA;
          end else begin
            oe_n    = 1'b0;
            state_n = S_PTR;
          end
        end
        S_PTR: if (scl_rise) begin
          sh_n      = byte_in;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_n   = byte_in[3:0];
            state_n = S_PTR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          sh_n      = byte_in;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            we      = 1'b1;
            ptr_n   = ptr_inc;
            state_n = S_WDATA_ACK;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) oe_n = 1'b1;
          else begin
            oe_n      = 1'b0;
            bit_cnt_n = '0;
            state_n   = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            oe_n = ~sh[7];
            sh_n = {sh[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = S_RACK;
          end
        end
        S_RACK: begin
          if (scl_fall) oe_n = 1'b0;
          else if (scl_rise) begin
            ptr_n = ptr_inc;
            if (!sda_f) begin
              sh_n    = rd_next;
              state_n = S_RDATA;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_IGNORE: oe_n = 1'b0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= RESET_VAL;
      wr_stb     <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      host_rdata <= RESET_VAL;
    end else begin
      wr_stb     <= we;
      host_rdata <= regs[host_idx];
      if (we) begin
        regs[ptr] <= byte_in;
        wr_idx    <= ptr;
        wr_data   <= byte_in;
      end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: bus-level controller tasks against a register-file model.
module tb_i2c_target;
  localparam logic [6:0] ADDR = 7'h3C;
  localparam logic [7:0] RV   = 8'h00;

  logic       clk = 1'b0, rst = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic       sda_line, sda_oe, wr_stb, busy;
  logic [3:0] wr_idx, host_idx = 4'd0;
  logic [7:0] wr_data, host_rdata;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target #(.ADDR(ADDR), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data),
    .host_idx(host_idx), .host_rdata(host_rdata), .busy(busy)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain register array and pointer updated by protocol rules.
  logic [7:0]  mregs [16];
  logic [3:0]  mptr;
  logic [7:0]  wq [$];
  logic [11:0] wr_q [$];
  logic [11:0] exp_wr [$];
  int          oe_cnt = 0, rise_viol = 0;
  logic        prev_oe = 1'b0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) wr_q.push_back({wr_idx, wr_data});
    if (sda_oe === 1'b1) oe_cnt++;
    if (sda_oe === 1'b1 && !prev_oe && scl) rise_viol++;
    prev_oe = sda_oe;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    tick(2); sda_m = b; tick(6); scl = 1'b1; tick(4); s = sda_line; tick(4); scl = 1'b0;
  endtask

  task automatic i2c_start;
    tick(2); sda_m = 1'b1; tick(4); scl = 1'b1; tick(6); sda_m = 1'b0; tick(6); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    tick(2); sda_m = 1'b0; tick(4); scl = 1'b1; tick(6); sda_m = 1'b1; tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, s); b[i] = s; end
    clk_bit(~ack, s);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) mregs[i] = RV;
    mptr = 4'd0;
  endtask

  // Write transaction using the bytes queued in wq.
  task automatic do_write(input logic [7:0] abyte, input logic [7:0] p, input string tag);
    logic ack;
    logic hit;
    hit = (abyte[7:1] == ADDR) && !abyte[0];
    wr_q.delete(); exp_wr.delete();
    i2c_start;
    send_byte(abyte, ack);
    chk({tag, "_aack"}, ack, hit);
    chk({tag, "_busy"}, busy, hit);
    send_byte(p, ack);
    chk({tag, "_pack"}, ack, hit);
    if (hit) mptr = p[3:0];
    foreach (wq[i]) begin
      send_byte(wq[i], ack);
      chk({tag, "_dack"}, ack, hit);
      if (hit) begin
        mregs[mptr] = wq[i];
        exp_wr.push_back({mptr, wq[i]});
        mptr = mptr + 4'd1;
      end
    end
    i2c_stop;
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_nwr"}, wr_q.size(), exp_wr.size());
    foreach (exp_wr[i])
      if (i < wr_q.size()) chk({tag, "_wr"}, wr_q[i], exp_wr[i]);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    i2c_start;
    if (set_ptr) begin
      send_byte({ADDR, 1'b0}, ack); chk({tag, "_wack"}, ack, 1'b1);
      send_byte(p, ack);            chk({tag, "_pack"}, ack, 1'b1);
      mptr = p[3:0];
      i2c_start;
    end
    send_byte({ADDR, 1'b1}, ack);
    chk({tag, "_rack"}, ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      chk({tag, "_data"}, b, mregs[mptr]);
      mptr = mptr + 4'd1;
    end
    tick(6);
    chk({tag, "_rel"}, sda_oe, 1'b0);
    i2c_stop;
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic host_chk(input logic [3:0] idx, input string tag);
    host_idx = idx; tick(2);
    chk(tag, host_rdata, mregs[idx]);
  endtask

  initial begin
    int oe0;
    logic ack;
    model_reset();
    tick(3);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_stb", wr_stb, 1'b0);
    chk("rst_idx", wr_idx, 4'd0);
    chk("rst_data", wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hrd", host_rdata, RV);
    rst = 1'b1; tick(4);
    chk("post_rst_oe", sda_oe, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    wq.delete(); wq.push_back(8'hAB); wq.push_back(8'hCD);
    do_write(8'h78, 8'h02, "wr");
    chk("wr_first", exp_wr.size() > 0 ? exp_wr[0] : 12'h0, 12'h2AB);
    host_chk(4'd3, "wr_host3");
    chk("wr_host3_val", host_rdata, 8'hCD);

    do_read(1'b1, 8'h02, 2, "rd");

    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    do_write(8'h78, 8'h0F, "wrap");
    host_chk(4'd15, "wrap_r15");
    host_chk(4'd0,  "wrap_r0");

    oe0 = oe_cnt;
    wq.delete(); wq.push_back(8'h55); wq.push_back(8'h66);
    do_write(8'h7A, 8'h01, "nomatch");
    chk("nomatch_oe", oe_cnt, oe0);

    // Reset while the target drives a 0 bit of a read.
    wq.delete(); wq.push_back(8'h0F);
    do_write(8'h78, 8'h05, "pre");
    i2c_start;
    send_byte(8'h78, ack); send_byte(8'h05, ack);
    i2c_start;
    send_byte(8'h79, ack);
    chk("mid_aack", ack, 1'b1);
    tick(6);
    chk("mid_drive", sda_oe, 1'b1);
    rst = 1'b0; #1;
    chk("mid_rst_oe", sda_oe, 1'b0);
    tick(3); scl = 1'b1; sda_m = 1'b1; tick(2);
    rst = 1'b1; tick(4);
    model_reset();
    wq.delete(); wq.push_back(8'h5A);
    do_write(8'h78, 8'h03, "post");
    host_chk(4'd5, "post_r5");
    host_chk(4'd3, "post_r3");

    // Short SDA low pulse while SCL is high; a following transaction must still work.
    tick(4); sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(8);
    chk("glitch_busy", busy, 1'b0);
    wq.delete(); wq.push_back(8'hE7);
    do_write(8'h78, 8'h09, "glitch_wr");

    for (int it = 0; it < 20; it++) begin
      int kind, n;
      logic [7:0] ab;
      kind = $urandom_range(0, 5);
      n    = $urandom_range(1, 4);
      if (kind <= 2) begin
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        ab = (kind == 2) ? {ADDR ^ 7'($urandom_range(1, 127)), 1'b0} : {ADDR, 1'b0};
        do_write(ab, 8'($urandom), "rnd_wr");
      end else begin
        do_read(kind == 3, 8'($urandom), n, "rnd_rd");
      end
    end

    for (int i = 0; i < 16; i++) host_chk(4'(i), "final_host");
    chk("oe_while_scl_high", rise_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for the SoC's open-drain `io_sda`/`io_scl` bus, the far end of the bus the SoC's I2C controller drives. It decodes START/STOP, matches a 7-bit address, and exposes a 16-byte register file. Writes use a pointer byte followed by auto-incrementing data bytes. Reads stream bytes back from the current pointer. The block sits on the board or testbench side of the bus and models a peripheral, so controller firmware can be exercised end to end.

## Interface
- `ADDR`, 7'h3C, 7-bit target address matched after START.
- `RESET_VAL`, 8'h00, reset value of every register-file byte.
- `clk`  in  1  system clock; must be ≥ 8× SCL frequency.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `scl_i`  in  1  SCL level seen on the bus (asynchronous).
- `sda_i`  in  1  SDA level seen on the bus (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low, 0 = release; never drives high.
- `wr_stb`  out  1  one-cycle pulse when a data byte is written to the register file.
- `wr_idx`  out  4  register index of the last write; valid with `wr_stb`, held afterwards.
- `wr_data`  out  8  byte written; valid with `wr_stb`, held afterwards.
- `host_idx`  in  4  local read index.
- `host_rdata`  out  8  registered copy of `regs[host_idx]`, one-cycle latency.
- `busy`  out  1  high from an address-matched START until STOP.

## Operation
- `scl_i` and `sda_i` pass through 2-flop synchronizers. Edges are detected on the synchronized values.
- Bus conditions, evaluated only while SCL is high:
  - START / repeated START: SDA falls.
  - STOP: SDA rises.
- On START, from any state: go to ADDR and set `bit_cnt`=0.
- On STOP, from any state: go to IDLE, set `sda_oe`=0 and `busy`=0.
- Bits are sampled MSB first on the SCL rising edge. `bit_cnt` counts 0..7; the 9th clock is the ACK slot.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If `[7:1]`==ADDR and R/W=0, go to ADDR_ACK (write).
    - If `[7:1]`==ADDR and R/W=1, go to ADDR_ACK (read).
    - Otherwise go to IGNORE; no ACK is driven.
  - ADDR_ACK: drive ACK for one SCL period.
    - Write: go to PTR.
    - Read: go to RDATA, loading the shift register with `regs[ptr]`.
  - PTR: shift 8 bits. `ptr` = `byte[3:0]`; upper bits are ignored. Go to PTR_ACK, then WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK.
    - Write `regs[ptr]`.
    - Pulse `wr_stb` in the cycle the 8th bit is sampled.
    - Increment `ptr` modulo 16 (15 wraps to 0).
    - After the ACK, return to WDATA.
  - RDATA: drive `sda_oe` = ~bit on each SCL falling edge for 8 bits, then release SDA and go to RACK.
  - RACK: sample the controller's ACK on the SCL rise and increment `ptr` modulo 16.
    - ACK (SDA=0): reload `regs[ptr]` and return to RDATA.
    - NACK (SDA=1): go to IGNORE.
  - IGNORE: `sda_oe`=0; wait for START or STOP.
- A repeated START after PTR keeps `ptr`, so a write-pointer-then-read sequence works.
- `busy` is set on entry to ADDR_ACK.
- Register-file reset: every byte = RESET_VAL, `ptr`=0.

## Timing
- Reset values while `reset` is low, and after release:
  - `sda_oe`=0, `wr_stb`=0, `wr_idx`=0, `wr_data`=0, `busy`=0.
  - `host_rdata`=RESET_VAL; state = IDLE.
- Input to detection latency: 2 clk (synchronizer) plus 1 clk (edge register).
- `sda_oe` changes only 1 clk after a detected SCL falling edge. It never changes while SCL is high, except release on STOP or START.
- ACK: `sda_oe`=1 from the falling edge after the 8th bit until the falling edge after the 9th clock.
- `wr_stb` is high for exactly 1 clk per written byte. `wr_idx`/`wr_data` update in the same cycle.
- `host_rdata` reflects a same-cycle bus write one cycle later.
- Reset asserted mid-transfer releases SDA immediately (asynchronously). After release, the block waits for a fresh START and ignores the rest of the frame.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN`
  - Defined: each synchronized line passes through a 3-sample majority filter before edge detection. Pulses of 1 clk are rejected; latency rises to 4 clk.
  - Undefined: the filter is absent and latency is 3 clk.
  - Protocol behaviour is otherwise identical.

## Test plan
- Write: START, 0x78, 0x02, 0xAB, 0xCD, STOP.
  - ACK on all 4 bytes.
  - `wr_stb` pulses twice: (2, 0xAB) then (3, 0xCD).
  - `host_idx`=3 gives 0xCD; `busy` returns to 0 after STOP.
- Read: START, 0x78, 0x02, repeated START, 0x79, read 2 bytes (ACK then NACK), STOP.
  - SDA carries 0xAB then 0xCD.
  - `sda_oe`=0 after the NACK.
- Wrap: pointer 0x0F, write 0x11 and 0x22.
  - `regs[15]`=0x11, `regs[0]`=0x22.
- Address mismatch: START, 0x7A, data bytes, STOP.
  - `sda_oe` stays 0 throughout; no `wr_stb`; `busy`=0.
- Reset mid-read:
  - Assert `reset` while driving a 0 bit; `sda_oe` drops to 0 within the same cycle.
  - After release, a new write transaction succeeds with registers back at RESET_VAL.
- With `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - A 1-clk SDA low glitch while SCL is high causes no START; state stays IDLE.
  - Without the macro, the same glitch moves the block to ADDR.
